maxpool_stream: RTL and testbench
=================================

Name: maxpool_stream

Overview:
- Parametrised streaming 2-D pooling layer for the CNN datapath; sits between a conv layer and the next stage (conv2 or fc).
- Consumes one multi-channel pixel per valid cycle in raster order and emits one pooled pixel per completed POOLxPOOL window (stride = POOL).
- Supports runtime max or average mode, arbitrary channel count and feature-map size; keeps one row of partial results in an internal line buffer.

Parameters:
- CHANNELS, 8, number of parallel feature channels.
- DATA_W, 8, bits per channel sample, two's-complement signed.
- IMG_W, 24, input feature-map width in pixels.
- IMG_H, 24, input feature-map height in pixels.
- POOL, 2, window size and stride; power of two, 2..8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-high: rst_n=1 at a rising edge resets the block.
- valid_in  in  1  data_in carries a pixel this cycle.
- data_in  in  CHANNELS*DATA_W  pixel; channel c occupies bits [c*DATA_W +: DATA_W].
- mode  in  1  0 = max pool, 1 = average pool; sampled per frame.
- valid_out  out  1  data_out holds a pooled pixel this cycle (single-cycle pulse).
- data_out  out  CHANNELS*DATA_W  pooled pixel, same packing as data_in.
- frame_last  out  1  asserted with valid_out on the final pooled pixel of a frame.

Behaviour:
- Reset: valid_out=0, frame_last=0, data_out=0, col/row counters=0, mode_q=0. Line-buffer contents are don't-care.
- Counters:
  - col advances 0..IMG_W-1 on each valid_in.
  - At col wrap, row advances 0..IMG_H-1.
  - At row wrap the frame ends and both counters return to 0.
  - Gaps (valid_in=0) freeze all state. No backpressure exists.
- Mode: mode_q is loaded on the valid pixel with row=0 and col=0, and is held for the whole frame. Mid-frame changes of mode are ignored.
- Window position: wc = col/POOL, rr = row%POOL, cc = col%POOL.
- Pixels with col >= (IMG_W/POOL)*POOL or row >= (IMG_H/POOL)*POOL are consumed but ignored (floor semantics).
- Combine, per channel:
  - Max mode: signed max.
  - Avg mode: signed sum; accumulator width DATA_W + 2*log2(POOL).
- Accumulation:
  - A horizontal accumulator is initialised when cc=0 and combined otherwise.
  - When cc=POOL-1:
    - rr=0: the result is written to line_buf[wc].
    - 0<rr<POOL-1: the result is combined with line_buf[wc] and written back.
    - rr=POOL-1: the result is combined with line_buf[wc] and the window completes.
  - The first contribution always overwrites, so stale buffer data never leaks.
- Output:
  - Latency is 1 cycle: the window completes on the valid_in edge, and valid_out and data_out appear on the next cycle.
  - Max mode: data_out is the max value.
  - Avg mode: data_out is the sum arithmetically shifted right by 2*log2(POOL) (floor toward -inf), truncated to DATA_W; the result cannot overflow.
- data_out holds its value between pulses. frame_last=1 only with the window at the last valid window row and column.
- Reset mid-frame: counters clear and any partial window is discarded. The next valid pixel is treated as (0,0).
- Back-to-back frames: the pixel after the wrap is (0,0) of the new frame, with no bubble needed. mode_q reloads on it.
- Line buffer: IMG_W/POOL entries x CHANNELS x acc width, implemented as registers or inferred RAM with read-during-write of the same address returning old data. A read and a write to the same wc in one cycle never occur across different rows.

Decomposition:
- Shared package cnn_pkg:
  - Default DATA_W and CHANNELS.
  - Localparams POOL_MAX=1'b0 and POOL_AVG=1'b1.
  - clog2 helper function.
- Sub-module pool_lane: one channel's combine/accumulate/shift datapath (mode, init flag, two operands -> result). It is instantiated CHANNELS times via generate.
- Counters, line-buffer addressing and output registers stay in maxpool_stream.

Test Plan:
- Bench configuration: IMG_W=4, IMG_H=4, POOL=2, CHANNELS=2, DATA_W=8.
- Max mode, continuous stream: ch0 = pixel index 0..15, ch1 = -index.
  - Required: 4 outputs; ch0 = 5,7,13,15; ch1 = 0,-2,-8,-10.
  - frame_last is on the 4th output, and each output arrives 1 cycle after pixel 5, 7, 13, 15 respectively.
- Avg mode, same stimulus.
  - ch0 = 2,4,10,12 (e.g. (0+1+4+5)/4 = 2.5 -> 2).
  - ch1 = -3,-5,-11,-13 (floor of -2.5 = -3).
- Random valid_in gaps (~50% duty), max mode.
  - Outputs are identical in value and order to the continuous case, and the valid_out count is 4.
- Mode toggled mid-frame after pixel 3.
  - The whole frame follows the mode sampled at pixel 0.
  - The next frame, streamed back-to-back, uses the new mode.
- Reset asserted after pixel 6, then a full frame of all -128 samples.
  - No output appears from the aborted frame.
  - Exactly 4 outputs of -128 appear in both modes, with frame_last on the last.
- IMG_W=5, IMG_H=5 build.
  - The 25-pixel frame yields 4 outputs; column 4 and row 4 are ignored.
  - frame_last fires on the output for window (1,1).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
package cnn_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_CHANNELS = 8;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/maxpool_stream_if.sv
// Pixel stream in / pooled pixel stream out for the pooling layer.
interface maxpool_stream_if
    import cnn_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned DATA_W   = DEF_DATA_W
);

    logic                         valid_in;
    logic [CHANNELS*DATA_W-1:0]   data_in;
    logic                         mode;
    logic                         valid_out;
    logic [CHANNELS*DATA_W-1:0]   data_out;
    logic                         frame_last;

    modport master (
        output valid_in, data_in, mode,
        input  valid_out, data_out, frame_last
    );

    modport slave (
        input  valid_in, data_in, mode,
        output valid_out, data_out, frame_last
    );

endinterface

// File: rtl/pool_lane.sv
// One channel of the pooling datapath: horizontal combine, vertical combine
// against the line buffer, and final max/average scaling.
module pool_lane
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SHIFT  = 2,
    localparam int unsigned ACC_W = DATA_W + SHIFT
) (
    input  logic                     mode,
    input  logic                     h_init,
    input  logic                     v_init,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [ACC_W-1:0]  h_acc,
    input  logic signed [ACC_W-1:0]  line_val,
    output logic signed [ACC_W-1:0]  h_res,
    output logic signed [ACC_W-1:0]  v_res,
    output logic signed [DATA_W-1:0] pooled
);

    function automatic logic signed [ACC_W-1:0] combine(
        input logic                    m,
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        if (m == POOL_AVG) begin
            return a + b;
        end
        return (a > b) ? a : b;
    endfunction

    logic signed [ACC_W-1:0] sample_ext;

    always_comb begin
        sample_ext = {{SHIFT{sample[DATA_W-1]}}, sample};
        h_res      = h_init ? sample_ext : combine(mode, h_acc, sample_ext);
        v_res      = v_init ? h_res : combine(mode, line_val, h_res);
        // Arithmetic shift floors toward -inf; the window mean always fits DATA_W.
        pooled     = (mode == POOL_AVG) ? DATA_W'(v_res >>> SHIFT) : DATA_W'(v_res);
    end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming POOLxPOOL max/average pooling with stride POOL over a raster-order
// multi-channel pixel stream; one row of partial windows is kept in a line buffer.
module maxpool_stream
    import cnn_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned IMG_W    = 24,
    parameter int unsigned IMG_H    = 24,
    parameter int unsigned POOL     = 2
) (
    input logic             clk,
    input logic             rst_n,
    maxpool_stream_if.slave bus
);

    localparam int unsigned LOG2P   = clog2(POOL);
    localparam int unsigned SHIFT   = 2 * LOG2P;
    localparam int unsigned ACC_W   = DATA_W + SHIFT;
    localparam int unsigned WC_N    = IMG_W / POOL;
    localparam int unsigned WR_N    = IMG_H / POOL;
    localparam int unsigned COL_LIM = WC_N * POOL;
    localparam int unsigned ROW_LIM = WR_N * POOL;
    localparam int unsigned CW      = clog2(IMG_W + 1);
    localparam int unsigned RW      = clog2(IMG_H + 1);
    localparam int unsigned WCW     = (clog2(WC_N) > 0) ? clog2(WC_N) : 1;

    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic             mode_q;

    logic             at_origin;
    logic             eff_mode;
    logic             in_range;
    logic             take;
    logic             col_end;
    logic             h_init;
    logic             v_init;
    logic             complete;
    logic             is_last;
    logic [LOG2P-1:0] cc;
    logic [LOG2P-1:0] rr;
    logic [WCW-1:0]   wc;

    logic                         valid_q;
    logic                         last_q;
    logic [CHANNELS*DATA_W-1:0]   data_q;
    logic [CHANNELS*DATA_W-1:0]   pooled_flat;

    logic signed [ACC_W-1:0] hacc_q   [CHANNELS];
    logic signed [ACC_W-1:0] h_res    [CHANNELS];
    logic signed [ACC_W-1:0] v_res    [CHANNELS];
    logic signed [ACC_W-1:0] line_rd  [CHANNELS];
    logic signed [ACC_W-1:0] line_buf [WC_N][CHANNELS];

    always_comb begin
        at_origin = (col_q == '0) && (row_q == '0);
        // The first pixel of a frame already uses the mode it is loading.
        eff_mode  = at_origin ? bus.mode : mode_q;
        in_range  = (col_q < CW'(COL_LIM)) && (row_q < RW'(ROW_LIM));
        cc        = col_q[LOG2P-1:0];
        rr        = row_q[LOG2P-1:0];
        wc        = WCW'(col_q >> LOG2P);
        take      = bus.valid_in && in_range;
        col_end   = (cc == LOG2P'(POOL - 1));
        h_init    = (cc == '0);
        v_init    = (rr == '0);
        complete  = take && col_end && (rr == LOG2P'(POOL - 1));
        is_last   = (wc == WCW'(WC_N - 1)) && ((row_q >> LOG2P) == RW'(WR_N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= POOL_MAX;
        end else if (bus.valid_in) begin
            if (at_origin) begin
                mode_q <= bus.mode;
            end
            if (col_q == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic signed [DATA_W-1:0] pooled;

        assign line_rd[c] = line_buf[wc][c];

        pool_lane #(
            .DATA_W (DATA_W),
            .SHIFT  (SHIFT)
        ) u_lane (
            .mode     (eff_mode),
            .h_init   (h_init),
            .v_init   (v_init),
            .sample   (bus.data_in[c*DATA_W +: DATA_W]),
            .h_acc    (hacc_q[c]),
            .line_val (line_rd[c]),
            .h_res    (h_res[c]),
            .v_res    (v_res[c]),
            .pooled   (pooled)
        );

        assign pooled_flat[c*DATA_W +: DATA_W] = pooled;
    end

    // Datapath storage needs no reset: every window starts by overwriting.
    always_ff @(posedge clk) begin
        if (take) begin
            for (int c = 0; c < CHANNELS; c++) begin
                hacc_q[c] <= h_res[c];
            end
            if (col_end && (rr != LOG2P'(POOL - 1))) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    line_buf[wc][c] <= v_res[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= complete;
            last_q  <= complete && is_last;
            if (complete) begin
                data_q <= pooled_flat;
            end
        end
    end

    assign bus.valid_out  = valid_q;
    assign bus.frame_last = last_q;
    assign bus.data_out   = data_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream: 4x4 and 5x5 builds, POOL=2, two 8-bit channels.
module tb_maxpool_stream;

    localparam int CH = 2;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool_stream_if #(.CHANNELS(CH), .DATA_W(DW)) bus4 ();
    maxpool_stream_if #(.CHANNELS(CH), .DATA_W(DW)) bus5 ();

    maxpool_stream #(
        .CHANNELS (CH), .DATA_W (DW), .IMG_W (4), .IMG_H (4), .POOL (2)
    ) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    maxpool_stream #(
        .CHANNELS (CH), .DATA_W (DW), .IMG_W (5), .IMG_H (5), .POOL (2)
    ) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q5[$];
    exp_t e4;
    exp_t e5;
    int   n_out4 = 0;
    int   n_out5 = 0;

    int m_col [2];
    int m_row [2];
    bit m_mode[2];
    int pix   [2][2][5][5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: rebuild each 2x2 window from the stored frame when its last pixel arrives.
    task automatic model_push(input int d, input int a, input int b, input bit m);
        int   w, h, r, c, wl, hl;
        int   v[2];
        exp_t e;
        w = (d == 0) ? 4 : 5;
        h = w;
        r = m_row[d];
        c = m_col[d];
        if (r == 0 && c == 0) m_mode[d] = m;
        pix[d][0][r][c] = a;
        pix[d][1][r][c] = b;
        wl = (w / 2) * 2;
        hl = (h / 2) * 2;
        if (c < wl && r < hl && (c % 2) == 1 && (r % 2) == 1) begin
            for (int ch = 0; ch < 2; ch++) begin
                int acc;
                int s;
                acc = m_mode[d] ? 0 : -1000;
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        s = pix[d][ch][r - 1 + dr][c - 1 + dc];
                        if (m_mode[d]) acc = acc + s;
                        else if (s > acc) acc = s;
                    end
                end
                if (m_mode[d]) acc = acc >>> 2;
                v[ch] = acc;
            end
            e.data = {v[1][7:0], v[0][7:0]};
            e.last = (c == wl - 1) && (r == hl - 1);
            e.cyc  = cyc + 1;
            if (d == 0) q4.push_back(e);
            else        q5.push_back(e);
        end
        c++;
        if (c == w) begin
            c = 0;
            r++;
            if (r == h) r = 0;
        end
        m_col[d] = c;
        m_row[d] = r;
    endtask

    task automatic drive(input int d, input int a, input int b, input bit m);
        logic [7:0] a8;
        logic [7:0] b8;
        @(negedge clk);
        a8 = a[7:0];
        b8 = b[7:0];
        bus4.valid_in = 1'b0;
        bus5.valid_in = 1'b0;
        if (d == 0) begin
            bus4.valid_in = 1'b1;
            bus4.data_in  = {b8, a8};
            bus4.mode     = m;
        end else begin
            bus5.valid_in = 1'b1;
            bus5.data_in  = {b8, a8};
            bus5.mode     = m;
        end
        model_push(d, a, b, m);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus4.valid_in = 1'b0;
            bus5.valid_in = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b1;
        bus4.valid_in = 1'b0;
        bus5.valid_in = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_col[d] = 0;
            m_row[d] = 0;
        end
    endtask

    // kind 0: ch0 = index, ch1 = -index; kind 1: all -128
    task automatic frame(input int d, input int kind, input bit m);
        int n;
        n = (d == 0) ? 16 : 25;
        for (int i = 0; i < n; i++) begin
            if (kind == 0) drive(d, i, -i, m);
            else           drive(d, -128, -128, m);
        end
    endtask

    always @(negedge clk) begin
        if (bus4.frame_last) check("last_without_valid4", 32'(bus4.valid_out), 32'd1);
        if (bus4.valid_out) begin
            n_out4++;
            check("unexpected_out4", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("data4", 32'(bus4.data_out), 32'(e4.data));
                check("frame_last4", 32'(bus4.frame_last), 32'(e4.last));
                check("latency4", cyc, e4.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (bus5.frame_last) check("last_without_valid5", 32'(bus5.valid_out), 32'd1);
        if (bus5.valid_out) begin
            n_out5++;
            check("unexpected_out5", 32'(q5.size() != 0), 32'd1);
            if (q5.size() != 0) begin
                e5 = q5.pop_front();
                check("data5", 32'(bus5.data_out), 32'(e5.data));
                check("frame_last5", 32'(bus5.frame_last), 32'(e5.last));
                check("latency5", cyc, e5.cyc);
            end
        end
    end

    initial begin
        int base;
        bus4.valid_in = 1'b0;
        bus4.data_in  = '0;
        bus4.mode     = 1'b0;
        bus5.valid_in = 1'b0;
        bus5.data_in  = '0;
        bus5.mode     = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_col[d]  = 0;
            m_row[d]  = 0;
            m_mode[d] = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("rst_valid4", 32'(bus4.valid_out), 32'd0);
        check("rst_data4",  32'(bus4.data_out),  32'd0);
        check("rst_last4",  32'(bus4.frame_last), 32'd0);
        check("rst_valid5", 32'(bus5.valid_out), 32'd0);
        check("rst_data5",  32'(bus5.data_out),  32'd0);
        check("rst_last5",  32'(bus5.frame_last), 32'd0);
        rst_n = 1'b0;
        idle(1);

        // Max, continuous
        base = n_out4;
        frame(0, 0, 1'b0);
        idle(3);
        check("count_max", n_out4 - base, 4);
        check("hold_data", 32'(bus4.data_out), 32'(e4.data));
        check("idle_valid", 32'(bus4.valid_out), 32'd0);

        // Average, continuous
        base = n_out4;
        frame(0, 0, 1'b1);
        idle(3);
        check("count_avg", n_out4 - base, 4);

        // Max with random gaps
        base = n_out4;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
            drive(0, i, -i, 1'b0);
        end
        idle(3);
        check("count_gaps", n_out4 - base, 4);

        // Mode flips after pixel 3; the next frame follows back-to-back in the new mode
        base = n_out4;
        for (int i = 0; i < 16; i++) drive(0, i, -i, (i <= 3) ? 1'b1 : 1'b0);
        frame(0, 0, 1'b0);
        idle(3);
        check("count_mode_toggle", n_out4 - base, 8);

        // Reset after pixel 6, then two frames of -128
        for (int i = 0; i <= 6; i++) drive(0, i, -i, 1'b0);
        idle(2);
        do_reset(2);
        base = n_out4;
        frame(0, 1, 1'b0);
        frame(0, 1, 1'b1);
        idle(3);
        check("count_after_reset", n_out4 - base, 8);

        // 5x5 build: last column and row are dropped
        base = n_out5;
        frame(1, 0, 1'b0);
        frame(1, 0, 1'b1);
        idle(3);
        check("count_5x5", n_out5 - base, 8);

        check("pending4", q4.size(), 32'd0);
        check("pending5", q5.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
